// File: rtl/pipe_channel_mux.sv
// Multi-channel packetiser: per-channel FIFOs, round-robin arbitration and
// header + burst framing onto one valid/ready stream for the host pipe-out FIFO.
module pipe_channel_mux #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                             sys_clk,
    input  logic                             sys_rst,
    input  logic [CHANNELS-1:0]              ch_enable,
    input  logic [CHANNELS-1:0]              ch_tx_valid,
    output logic [CHANNELS-1:0]              ch_tx_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   ch_tx,
    output logic [CHANNELS*(ADDR_WIDTH+1)-1:0] ch_count,
    output logic                             sys_tx_valid,
    input  logic                             sys_tx_ready,
    output logic [DATA_WIDTH-1:0]            sys_tx
);

    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNTW  = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  chan_q, chan_d;
    logic [CW-1:0]                  last_grant_q, last_grant_d;
    logic [7:0]                     len_q, len_d;
    logic [7:0]                     rem_q, rem_d;
    logic [CW-1:0]                  grant_s;
    logic                           grant_found_s;
    logic [CNTW-1:0]                grant_cnt_s;
    logic [CHANNELS-1:0]            push_s, pop_s, full_s, elig_s;
    logic [CHANNELS*DATA_WIDTH-1:0] head_s;
    logic [CHANNELS*CNTW-1:0]       count_flat_s;

    // Index of the channel 'offset' positions after 'base', wrapping at CHANNELS.
    function automatic logic [CW-1:0] rr_next(input logic [CW-1:0] base, input int offset);
        logic [CW:0] sum;
        sum = {1'b0, base} + (CW+1)'(offset);
        if (sum >= (CW+1)'(CHANNELS)) begin
            sum = sum - (CW+1)'(CHANNELS);
        end else begin
            sum = sum;
        end
        return sum[CW-1:0];
    endfunction

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_fifo
            logic [DATA_WIDTH-1:0] mem_q [DEPTH];
            logic [ADDR_WIDTH-1:0] wr_ptr_q;
            logic [ADDR_WIDTH-1:0] rd_ptr_q;
            logic [CNTW-1:0]       count_q;

            assign full_s[g]      = (count_q == CNTW'(DEPTH));
            assign ch_tx_ready[g] = ~full_s[g] & ~sys_rst;
            assign push_s[g]      = ch_tx_valid[g] & ch_tx_ready[g];
            // Only the active burst drains its own channel, so pop never underflows.
            assign pop_s[g]       = (state_q == S_DATA) & sys_tx_ready & (chan_q == CW'(g));
            assign elig_s[g]      = (count_q != {CNTW{1'b0}}) & ch_enable[g];
            assign head_s[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q];
            assign count_flat_s[g*CNTW +: CNTW]       = count_q;

            // FIFO storage write port; contents need no reset.
            always_ff @(posedge sys_clk) begin
                if (push_s[g]) begin
                    mem_q[wr_ptr_q] <= ch_tx[g*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            // FIFO pointers and occupancy.
            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    wr_ptr_q <= {ADDR_WIDTH{1'b0}};
                    rd_ptr_q <= {ADDR_WIDTH{1'b0}};
                    count_q  <= {CNTW{1'b0}};
                end else begin
                    if (push_s[g]) begin
                        wr_ptr_q <= wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end
                    if (pop_s[g]) begin
                        rd_ptr_q <= rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end
                    count_q <= count_q + CNTW'(push_s[g]) - CNTW'(pop_s[g]);
                end
            end
        end
    endgenerate

    assign ch_count    = count_flat_s;
    assign grant_cnt_s = count_flat_s[grant_s*CNTW +: CNTW];

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        grant_found_s = 1'b0;
        grant_s       = {CW{1'b0}};
        for (int k = 1; k <= CHANNELS; k++) begin
            if (!grant_found_s && elig_s[rr_next(last_grant_q, k)]) begin
                grant_found_s = 1'b1;
                grant_s       = rr_next(last_grant_q, k);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Packet FSM state and burst bookkeeping registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            chan_q       <= {CW{1'b0}};
            last_grant_q <= CW'(CHANNELS - 1);
            len_q        <= 8'd0;
            rem_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
        end
    end

    // Packet FSM next-state logic.
    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        last_grant_d = last_grant_q;
        len_d        = len_q;
        rem_d        = rem_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found_s) begin
                    chan_d       = grant_s;
                    last_grant_d = grant_s;
                    state_d      = S_HEADER;
                    if (grant_cnt_s >= CNTW'(MAX_BURST)) begin
                        len_d = 8'(MAX_BURST);
                    end else begin
                        len_d = 8'(grant_cnt_s);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HEADER: begin
                if (sys_tx_ready) begin
                    rem_d   = len_q;
                    state_d = S_DATA;
                end else begin
                    state_d = S_HEADER;
                end
            end
            S_DATA: begin
                if (sys_tx_ready) begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output word: header carries channel in the top byte and burst length below.
    always_comb begin
        sys_tx_valid = 1'b0;
        sys_tx       = {DATA_WIDTH{1'b0}};
        case (state_q)
            S_HEADER: begin
                sys_tx_valid = 1'b1;
                sys_tx       = {8'(chan_q), (DATA_WIDTH-8)'(len_q)};
            end
            S_DATA: begin
                sys_tx_valid = 1'b1;
                sys_tx       = head_s[chan_q*DATA_WIDTH +: DATA_WIDTH];
            end
            default: begin
                sys_tx_valid = 1'b0;
                sys_tx       = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

endmodule

// File: doc/pipe_channel_mux.md
# pipe_channel_mux

Multi-channel packetising front end for the host pipe-out path, in the `sys_clk` domain. It accepts `CHANNELS` independent valid/ready word streams and buffers each in its own synchronous FIFO. Channels are served round-robin, and each burst is emitted as one header word followed by up to `MAX_BURST` data words on a single valid/ready output. The output feeds the `sys_tx_*` push side of the pipe-out async FIFO, so several producers can share one host pipe and the host can demultiplex by header.

## Interface
Parameters:
- `CHANNELS`, 4: number of input channels; 1..256.
- `DATA_WIDTH`, 16: word width; ≥ 16.
- `ADDR_WIDTH`, 4: per-channel FIFO depth is 2^`ADDR_WIDTH` words; ≥ 1.
- `MAX_BURST`, 8: maximum data words per packet; 1..min(2^`ADDR_WIDTH`, 255).

Ports:
- `sys_clk`  in  1  single clock for the whole block.
- `sys_rst`  in  1  reset, synchronous, active-high.
- `ch_enable`  in  `CHANNELS`  per-channel arbitration enable.
- `ch_tx_valid`  in  `CHANNELS`  per-channel input valid.
- `ch_tx_ready`  out  `CHANNELS`  per-channel input ready.
- `ch_tx`  in  `CHANNELS*DATA_WIDTH`  input data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `ch_count`  out  `CHANNELS*(ADDR_WIDTH+1)`  per-channel FIFO occupancy, packed the same way.
- `sys_tx_valid`  out  1  output word valid.
- `sys_tx_ready`  in  1  downstream ready.
- `sys_tx`  out  `DATA_WIDTH`  output word (header or data).

## Operation
- **Input side.** `ch_tx_ready[i]` = ~full_i & ~`sys_rst`. A push occurs when `ch_tx_valid[i]` & `ch_tx_ready[i]`. A push while full is ignored.
- **Occupancy.** `ch_count[i]` is registered and updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged. Range is 0..2^`ADDR_WIDTH`.
- **Eligibility.** Channel i is eligible when `ch_count[i]` ≠ 0 and `ch_enable[i]` = 1.
- **FSM states:** IDLE, HEADER, DATA.
- **IDLE.**
  - If any channel is eligible, grant the first eligible channel searching upward from `last_grant`+1, wrapping at `CHANNELS`.
  - Latch `chan` = grant and `len` = min(`ch_count[grant]`, `MAX_BURST`), set `last_grant` = grant, then go to HEADER.
  - Otherwise stay in IDLE.
- **HEADER.**
  - `sys_tx_valid` = 1.
  - `sys_tx` = {`chan` in bits [DW-1:DW-8], zero-extended `len` in bits [DW-9:0]}.
  - On `sys_tx_ready`: set `remaining` = `len` and go to DATA.
- **DATA.**
  - `sys_tx_valid` = 1 and `sys_tx` = head word of FIFO `chan` (asynchronous-read memory).
  - Each accepted word pops FIFO `chan` and decrements `remaining`.
  - When the word with `remaining` = 1 is accepted, go to IDLE.
- **Data availability.** `len` ≤ occupancy at grant time, and only this block pops the FIFO, so DATA never underflows.
- **Mid-burst changes.** Deasserting `ch_enable[chan]` during HEADER or DATA has no effect; the burst completes. Pushes to any channel continue during a burst.
- **Width rules.** `len` and `remaining` are 8 bits wide. Header bits [DW-9:8] are zero when DW > 16.

## Timing
- **Reset values:**
  - `sys_tx_valid` = 0, `sys_tx` = 0, `ch_tx_ready` = all 0 during reset, `ch_count` = 0.
  - State = IDLE, `last_grant` = `CHANNELS`-1 (so channel 0 has first priority), all FIFO pointers = 0.
- **Reset mid-burst.** All FIFOs are discarded and the current packet is truncated. `sys_tx_valid` is low the cycle after reset is sampled.
- **Latency.** A word pushed into an empty channel at cycle t gives: `ch_count` = 1 at t+1, grant at t+1, header valid at t+2, first data at t+3 when `sys_tx_ready` is held high.
- **Throughput.** One word per cycle within a packet. There is exactly one IDLE cycle between packets, so a packet costs `len`+2 cycles with no backpressure.
- **Output handshake.** `sys_tx_valid` and `sys_tx` stay stable until accepted. `sys_tx_valid` never drops between the header and the last data word of a packet.
- **Full-FIFO pop and push.** When a full FIFO is popped, `ch_tx_ready` rises the next cycle; a push in the same cycle as the pop is refused.

## Test plan
1. **Reset.** Assert `sys_rst` for 2 cycles with all inputs active.
   - Required: `sys_tx_valid` = 0, `ch_tx_ready` = 0000, all `ch_count` = 0.
   - After release: `ch_tx_ready` = 1111.
2. **Single packet.** Push 0xA001, 0xA002, 0xA003 into ch2 at cycles 0–2, with `sys_tx_ready` = 1 and all channels enabled.
   - Required: header 0x0201 at cycle 2; the short packet leaves the remaining words to later packets.
   - Required ordering: all three words are delivered in order, and the sum of header lengths = 3.
3. **Burst splitting.** Fill ch0 with 16 words while `ch_enable` = 0, then enable.
   - Required: packets 0x0008 + 8 words, 0x0008 + 8 words.
   - Required: `ch_count[0]` steps 16 → 8 → 0; one IDLE gap between packets.
4. **Round-robin.** Preload ch0, ch1, ch3 with 2 words each; ch2 empty; then enable all.
   - Required header order: 0x0002, 0x0102, 0x0302.
   - Then push 1 word to ch1 and 1 to ch0. Required next headers: 0x0001, 0x0101 (search restarts after ch3).
5. **Backpressure and full.** Hold `sys_tx_ready` = 0 and push 17 words into ch1.
   - Required: `ch_tx_ready[1]` low after the 16th push; `ch_count[1]` = 16; 17th word dropped.
   - Required: header held stable on `sys_tx` with `sys_tx_valid` = 1.
   - Toggle `sys_tx_ready` 1/0. Required: exactly one word advances per high cycle.
6. **Reset mid-packet.** Assert `sys_rst` after 3 of 8 data words have been accepted.
   - Required: `sys_tx_valid` = 0 next cycle and all `ch_count` = 0.
   - After release: the next packet starts with channel 0 priority.
